pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the next-generation, parametrised in-order pipelined RV32 core that succeeds the single-cycle datapath. It tracks the valid bit and destination register of every stage from ID to WB. It also detects RAW hazards at ID, generates forwarding selects, per-stage stall and flush controls, and the WB regfile write strobe. It keeps a retired-instruction counter. Stages: 0=IF, 1=ID, 2=EX, 3..STAGES-2=MEM, STAGES-1=WB.

Parameters:
STAGES, 5, pipeline depth; legal range is 5 or more.
FWD_EN, 1, 1=forwarding enabled; 0=every RAW match stalls.
LOAD_STAGE, 4, first stage index at which load data can be forwarded; legal range 3..STAGES-1.
SEL_W, $clog2(STAGES), width of the forwarding select.
CNT_W, 64, width of the retire counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_valid_i  in  1  IF holds a valid instruction
id_rs1_en_i  in  1  ID reads rs1
id_rs1_idx_i  in  5  rs1 index
id_rs2_en_i  in  1  ID reads rs2
id_rs2_idx_i  in  5  rs2 index
id_rd_en_i  in  1  ID instruction writes rd
id_rd_idx_i  in  5  rd index
id_is_load_i  in  1  ID instruction is a load
ex_redirect_i  in  1  taken branch/jump resolved in EX
excp_i  in  1  exception raised by the EX instruction
mem_busy_i  in  1  memory stage not ready
stage_valid_o  out  STAGES-1  bit k-1 = valid of stage k (k=1..STAGES-1)
stall_o  out  STAGES  bit k=1: stage k holds its register this cycle
id_hazard_o  out  1  ID stalled on RAW hazard
rs1_fwd_sel_o  out  SEL_W  0=regfile, else source stage index
rs2_fwd_sel_o  out  SEL_W  as above, for rs2
wb_rd_en_o  out  1  regfile write enable
wb_rd_idx_o  out  5  regfile write index
instret_o  out  CNT_W  retired-instruction count

Behaviour:
- State per stage k=1..STAGES-1: valid_q[k]. Per stage k=2..STAGES-1 also rd_en_q, rd_idx_q, is_load_q; these move with valid.
- Reset (sync, high): all valid_q=0, instret=0. All outputs are therefore 0 in the cycle after reset, including stall_o, selects and wb_rd_en_o. Reset mid-stream discards all in-flight state.
- Match, per source s: a stage k in 2..STAGES-1 matches when all of these hold:
  - s_en=1 and s_idx!=0;
  - valid_q[k]=1 and rd_en_q[k]=1;
  - rd_idx_q[k]=s_idx.
- hazard_raw: valid_q[1]=1 and some source has a match where FWD_EN=0, or (is_load_q[k]=1 and k<LOAD_STAGE).
- fwd_sel: the smallest matching k (youngest producer). It is 0 when there is no match, when FWD_EN=0, or when hazard_raw=1.
- wb_rd_en_o=valid_q[STAGES-1]&rd_en_q[STAGES-1]; wb_rd_idx_o=rd_idx_q[STAGES-1]. WB is also a forwarding source, so the regfile needs no write-through.
- Next-state priority (evaluated each cycle):
  1. mem_busy_i=1:
     - stall_o[0..STAGES-2]=1; those stages hold.
     - valid_q[STAGES-1]<=0 (bubble into WB).
     - ex_redirect_i is ignored; the producer holds it until stall_o[2]=0.
     - If excp_i=1: valid_q[1]<=0 and valid_q[2]<=0 (faulting instruction removed); stages >=3 hold.
  2. excp_i=1 (not busy): valid_q[1]<=0, valid_q[2]<=0, valid_q[3]<=0 (faulting instruction killed, no retire). Stages >=4 advance.
  3. ex_redirect_i=1 (not busy): valid_q[1]<=0, valid_q[2]<=0 (younger instructions killed); valid_q[3]<=valid_q[2] (branch proceeds). Stages >=4 advance.
  4. hazard_raw=1: stall_o[0]=stall_o[1]=1; valid_q[2]<=0 (bubble); stages >=3 advance.
  5. Normal: valid_q[1]<=if_valid_i; valid_q[k]<=valid_q[k-1].
- id_hazard_o=hazard_raw and no excp/redirect/busy. Under excp or redirect the ID instruction dies and is not stalled.
- stall_o[STAGES-1]=0 always. stall_o is combinational; valid_q is registered.
- instret increments by 1 each cycle valid_q[STAGES-1]=1 (including during mem_busy), wraps modulo 2^CNT_W.

Test Plan:
- Reset mid-stream (STAGES=5), all valids 1, reset one cycle -> stage_valid_o=0, stall_o=0, wb_rd_en_o=0, instret_o=0.
- ALU rd=x5 in EX, ID reads rs1=x5, rs2=x0 -> rs1_fwd_sel_o=2, rs2_fwd_sel_o=0, id_hazard_o=0. Repeat with FWD_EN=0 -> id_hazard_o=1, sel=0.
- Load rd=x7 in EX, ID reads x7 (LOAD_STAGE=4):
  - 2 cycles of id_hazard_o=1 with stall_o=5'b00011 and bubbles in EX;
  - third cycle rs1_fwd_sel_o=4, id_hazard_o=0.
- ex_redirect_i with a branch in EX and valids 4'b1111 -> next stage_valid_o=4'b1100. Branch is in stage 3; no stall.
- mem_busy_i for 3 cycles, excp_i in cycle 2:
  - stall_o=5'b01111 throughout; WB gets bubbles;
  - stages 1,2 invalid after excp; stage 3 instruction retires after busy drops.
- CNT_W=4, 17 consecutive retirements -> instret_o wraps 15->0, ending at 1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the in-order RV32 core: per-stage valid/rd tracking,
// RAW hazard detection at ID, forwarding selects, stall/flush and retire counting.
module pipe_ctrl #(
    parameter int STAGES     = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STAGE = 4,
    parameter int SEL_W      = $clog2(STAGES),
    parameter int CNT_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid_i,
    input  logic              id_rs1_en_i,
    input  logic [4:0]        id_rs1_idx_i,
    input  logic              id_rs2_en_i,
    input  logic [4:0]        id_rs2_idx_i,
    input  logic              id_rd_en_i,
    input  logic [4:0]        id_rd_idx_i,
    input  logic              id_is_load_i,
    input  logic              ex_redirect_i,
    input  logic              excp_i,
    input  logic              mem_busy_i,
    output logic [STAGES-2:0] stage_valid_o,
    output logic [STAGES-1:0] stall_o,
    output logic              id_hazard_o,
    output logic [SEL_W-1:0]  rs1_fwd_sel_o,
    output logic [SEL_W-1:0]  rs2_fwd_sel_o,
    output logic              wb_rd_en_o,
    output logic [4:0]        wb_rd_idx_o,
    output logic [CNT_W-1:0]  instret_o
);

    logic [STAGES-1:1] valid_q;
    logic [STAGES-1:2] rd_en_q;
    logic [STAGES-1:2] is_load_q;
    logic [4:0]        rd_idx_q [2:STAGES-1];
    logic [CNT_W-1:0]  instret_q;

    logic              hazard_raw;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              must_stall;
    logic [SEL_W-1:0]  rs1_sel;
    logic [SEL_W-1:0]  rs2_sel;

    // Scan oldest to youngest so the last hit left standing is the youngest producer.
    always_comb begin
        hazard_raw = 1'b0;
        rs1_hit    = 1'b0;
        rs2_hit    = 1'b0;
        must_stall = 1'b0;
        rs1_sel    = '0;
        rs2_sel    = '0;
        for (int unsigned k = STAGES - 1; k >= 2; k--) begin
            rs1_hit = id_rs1_en_i && (id_rs1_idx_i != 5'd0) && valid_q[k] && rd_en_q[k]
                      && (rd_idx_q[k] == id_rs1_idx_i);
            rs2_hit = id_rs2_en_i && (id_rs2_idx_i != 5'd0) && valid_q[k] && rd_en_q[k]
                      && (rd_idx_q[k] == id_rs2_idx_i);
            must_stall = (FWD_EN == 0) || (is_load_q[k] && (int'(k) < LOAD_STAGE));
            if (rs1_hit) rs1_sel = SEL_W'(k);
            if (rs2_hit) rs2_sel = SEL_W'(k);
            if ((rs1_hit || rs2_hit) && must_stall) hazard_raw = 1'b1;
        end
        hazard_raw = hazard_raw && valid_q[1];
        if ((FWD_EN == 0) || hazard_raw) begin
            rs1_sel = '0;
            rs2_sel = '0;
        end
    end

    assign id_hazard_o = hazard_raw && !excp_i && !ex_redirect_i && !mem_busy_i;

    always_comb begin
        stall_o = '0;
        if (mem_busy_i)
            stall_o[STAGES-2:0] = '1;
        else if (id_hazard_o)
            stall_o[1:0] = 2'b11;
    end

    assign stage_valid_o = valid_q;
    assign rs1_fwd_sel_o = rs1_sel;
    assign rs2_fwd_sel_o = rs2_sel;
    assign wb_rd_en_o    = valid_q[STAGES-1] && rd_en_q[STAGES-1];
    assign wb_rd_idx_o   = rd_idx_q[STAGES-1];
    assign instret_o     = instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            rd_en_q   <= '0;
            is_load_q <= '0;
            instret_q <= '0;
            for (int unsigned k = 2; k < STAGES; k++)
                rd_idx_q[k] <= '0;
        end else begin
            if (valid_q[STAGES-1])
                instret_q <= instret_q + CNT_W'(1);
            if (mem_busy_i) begin
                valid_q[STAGES-1] <= 1'b0;
                if (excp_i)
                    valid_q[2:1] <= 2'b00;
            end else begin
                rd_en_q     <= {rd_en_q[STAGES-2:2], id_rd_en_i};
                is_load_q   <= {is_load_q[STAGES-2:2], id_is_load_i};
                rd_idx_q[2] <= id_rd_idx_i;
                for (int unsigned k = 3; k < STAGES; k++)
                    rd_idx_q[k] <= rd_idx_q[k-1];
                valid_q <= {valid_q[STAGES-2:1], if_valid_i};
                if (excp_i)
                    valid_q[3:1] <= '0;
                else if (ex_redirect_i)
                    valid_q[2:1] <= '0;
                else if (hazard_raw)
                    // hazard_raw implies valid_q[1]=1, so holding ID is writing 1
                    valid_q[2:1] <= 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl: three configurations share stimulus
// and are checked every cycle against a record-per-stage pipeline model.
module tb_pipe_ctrl;

    localparam int CFG_S  [3] = '{5, 5, 7};
    localparam int CFG_FW [3] = '{1, 0, 1};
    localparam int CFG_LS [3] = '{4, 4, 5};
    localparam int CFG_CW [3] = '{64, 4, 64};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       if_valid = 1'b0;
    logic       rs1_en = 1'b0, rs2_en = 1'b0, rd_en = 1'b0, is_load = 1'b0;
    logic [4:0] rs1_idx = '0, rs2_idx = '0, rd_idx = '0;
    logic       redir = 1'b0, excp = 1'b0, busy = 1'b0;

    always #5 clk = ~clk;

    logic [3:0]  sv0, sv1;
    logic [5:0]  sv2;
    logic [4:0]  st0, st1;
    logic [6:0]  st2;
    logic        hz0, hz1, hz2, wbe0, wbe1, wbe2;
    logic [2:0]  s1_0, s1_1, s1_2, s2_0, s2_1, s2_2;
    logic [4:0]  wbi0, wbi1, wbi2;
    logic [63:0] cnt0, cnt2;
    logic [3:0]  cnt1;

    pipe_ctrl #(.STAGES(CFG_S[0]), .FWD_EN(CFG_FW[0]), .LOAD_STAGE(CFG_LS[0]), .SEL_W(3), .CNT_W(CFG_CW[0])) u_fwd (
        .clk(clk), .reset(reset), .if_valid_i(if_valid),
        .id_rs1_en_i(rs1_en), .id_rs1_idx_i(rs1_idx), .id_rs2_en_i(rs2_en), .id_rs2_idx_i(rs2_idx),
        .id_rd_en_i(rd_en), .id_rd_idx_i(rd_idx), .id_is_load_i(is_load),
        .ex_redirect_i(redir), .excp_i(excp), .mem_busy_i(busy),
        .stage_valid_o(sv0), .stall_o(st0), .id_hazard_o(hz0),
        .rs1_fwd_sel_o(s1_0), .rs2_fwd_sel_o(s2_0),
        .wb_rd_en_o(wbe0), .wb_rd_idx_o(wbi0), .instret_o(cnt0));

    pipe_ctrl #(.STAGES(CFG_S[1]), .FWD_EN(CFG_FW[1]), .LOAD_STAGE(CFG_LS[1]), .SEL_W(3), .CNT_W(CFG_CW[1])) u_nofwd (
        .clk(clk), .reset(reset), .if_valid_i(if_valid),
        .id_rs1_en_i(rs1_en), .id_rs1_idx_i(rs1_idx), .id_rs2_en_i(rs2_en), .id_rs2_idx_i(rs2_idx),
        .id_rd_en_i(rd_en), .id_rd_idx_i(rd_idx), .id_is_load_i(is_load),
        .ex_redirect_i(redir), .excp_i(excp), .mem_busy_i(busy),
        .stage_valid_o(sv1), .stall_o(st1), .id_hazard_o(hz1),
        .rs1_fwd_sel_o(s1_1), .rs2_fwd_sel_o(s2_1),
        .wb_rd_en_o(wbe1), .wb_rd_idx_o(wbi1), .instret_o(cnt1));

    pipe_ctrl #(.STAGES(CFG_S[2]), .FWD_EN(CFG_FW[2]), .LOAD_STAGE(CFG_LS[2]), .SEL_W(3), .CNT_W(CFG_CW[2])) u_deep (
        .clk(clk), .reset(reset), .if_valid_i(if_valid),
        .id_rs1_en_i(rs1_en), .id_rs1_idx_i(rs1_idx), .id_rs2_en_i(rs2_en), .id_rs2_idx_i(rs2_idx),
        .id_rd_en_i(rd_en), .id_rd_idx_i(rd_idx), .id_is_load_i(is_load),
        .ex_redirect_i(redir), .excp_i(excp), .mem_busy_i(busy),
        .stage_valid_o(sv2), .stall_o(st2), .id_hazard_o(hz2),
        .rs1_fwd_sel_o(s1_2), .rs2_fwd_sel_o(s2_2),
        .wb_rd_en_o(wbe2), .wb_rd_idx_o(wbi2), .instret_o(cnt2));

    logic [7:0]  d_sv  [3];
    logic [7:0]  d_st  [3];
    logic        d_hz  [3];
    logic [2:0]  d_s1  [3];
    logic [2:0]  d_s2  [3];
    logic        d_wbe [3];
    logic [4:0]  d_wbi [3];
    logic [63:0] d_cnt [3];

    assign d_sv[0] = {4'b0, sv0};  assign d_sv[1] = {4'b0, sv1};  assign d_sv[2] = {2'b0, sv2};
    assign d_st[0] = {3'b0, st0};  assign d_st[1] = {3'b0, st1};  assign d_st[2] = {1'b0, st2};
    assign d_hz[0] = hz0;          assign d_hz[1] = hz1;          assign d_hz[2] = hz2;
    assign d_s1[0] = s1_0;         assign d_s1[1] = s1_1;         assign d_s1[2] = s1_2;
    assign d_s2[0] = s2_0;         assign d_s2[1] = s2_1;         assign d_s2[2] = s2_2;
    assign d_wbe[0] = wbe0;        assign d_wbe[1] = wbe1;        assign d_wbe[2] = wbe2;
    assign d_wbi[0] = wbi0;        assign d_wbi[1] = wbi1;        assign d_wbi[2] = wbi2;
    assign d_cnt[0] = cnt0;        assign d_cnt[1] = {60'b0, cnt1}; assign d_cnt[2] = cnt2;

    // Model: one instruction record per stage (index 1..S-1), per configuration.
    bit         mv  [3][8];
    bit         men [3][8];
    bit         mld [3][8];
    bit [4:0]   mrd [3][8];
    bit [63:0]  mcnt[3];

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cfg%0d t=%0t: got %0h expected %0h", name, c, $time, act, exp);
        end
    endtask

    task automatic model_eval(input int c, output bit [7:0] sv, output bit [7:0] st, output bit idh,
                              output bit hz, output bit [2:0] s1, output bit [2:0] s2,
                              output bit wbe, output bit [4:0] wbi);
        int s;
        bit m1, m2;
        s = CFG_S[c];
        sv = '0;
        for (int k = 1; k < s; k++) sv[k-1] = mv[c][k];
        hz = 1'b0; s1 = '0; s2 = '0;
        for (int k = s - 1; k >= 2; k--) begin
            m1 = rs1_en && rs1_idx != 0 && mv[c][k] && men[c][k] && mrd[c][k] == rs1_idx;
            m2 = rs2_en && rs2_idx != 0 && mv[c][k] && men[c][k] && mrd[c][k] == rs2_idx;
            if (m1) s1 = 3'(k);
            if (m2) s2 = 3'(k);
            if ((m1 || m2) && (CFG_FW[c] == 0 || (mld[c][k] && k < CFG_LS[c]))) hz = 1'b1;
        end
        hz = hz && mv[c][1];
        if (CFG_FW[c] == 0 || hz) begin s1 = '0; s2 = '0; end
        if (busy) begin
            idh = 1'b0;
            st  = (8'd1 << (s - 1)) - 8'd1;
        end else begin
            idh = hz && !excp && !redir;
            st  = idh ? 8'd3 : 8'd0;
        end
        wbe = mv[c][s-1] && men[c][s-1];
        wbi = mrd[c][s-1];
    endtask

    task automatic model_step();
        bit [7:0] sv, st;
        bit idh, hz, wbe;
        bit [2:0] s1, s2;
        bit [4:0] wbi;
        int s;
        for (int c = 0; c < 3; c++) begin
            s = CFG_S[c];
            model_eval(c, sv, st, idh, hz, s1, s2, wbe, wbi);
            if (reset) begin
                for (int k = 0; k < 8; k++) begin
                    mv[c][k] = 0; men[c][k] = 0; mld[c][k] = 0; mrd[c][k] = 0;
                end
                mcnt[c] = 0;
            end else begin
                if (mv[c][s-1]) begin
                    mcnt[c] = mcnt[c] + 64'd1;
                    if (CFG_CW[c] < 64) mcnt[c] = mcnt[c] & ((64'd1 << CFG_CW[c]) - 64'd1);
                end
                if (busy) begin
                    mv[c][s-1] = 0;
                    if (excp) begin mv[c][1] = 0; mv[c][2] = 0; end
                end else begin
                    for (int k = s - 1; k >= 3; k--) begin
                        mv[c][k] = mv[c][k-1]; men[c][k] = men[c][k-1];
                        mld[c][k] = mld[c][k-1]; mrd[c][k] = mrd[c][k-1];
                    end
                    mv[c][2] = mv[c][1]; men[c][2] = rd_en; mld[c][2] = is_load; mrd[c][2] = rd_idx;
                    mv[c][1] = if_valid;
                    if (excp) begin
                        mv[c][1] = 0; mv[c][2] = 0; mv[c][3] = 0;
                    end else if (redir) begin
                        mv[c][1] = 0; mv[c][2] = 0;
                    end else if (hz) begin
                        mv[c][1] = 1; mv[c][2] = 0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        bit [7:0] sv, st;
        bit idh, hz, wbe;
        bit [2:0] s1, s2;
        bit [4:0] wbi;
        @(negedge clk);
        if (chk_en) begin
            for (int c = 0; c < 3; c++) begin
                model_eval(c, sv, st, idh, hz, s1, s2, wbe, wbi);
                check("stage_valid", c, 64'(d_sv[c]), 64'(sv));
                check("stall", c, 64'(d_st[c]), 64'(st));
                check("id_hazard", c, 64'(d_hz[c]), 64'(idh));
                check("rs1_sel", c, 64'(d_s1[c]), 64'(s1));
                check("rs2_sel", c, 64'(d_s2[c]), 64'(s2));
                check("wb_rd_en", c, 64'(d_wbe[c]), 64'(wbe));
                if (wbe) check("wb_rd_idx", c, 64'(d_wbi[c]), 64'(wbi));
                check("instret", c, d_cnt[c], mcnt[c]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; if_valid = 0; rs1_en = 0; rs2_en = 0; rd_en = 0; is_load = 0;
        rs1_idx = 0; rs2_idx = 0; rd_idx = 0; redir = 0; excp = 0; busy = 0;
    endtask

    initial begin
        next_cycle();
        idle_inputs();
        chk_en = 1'b1;

        // reset mid-stream
        if_valid = 1; rd_en = 1; rd_idx = 5'd1;
        repeat (4) next_cycle();
        @(negedge clk);
        check("fill_valid", 0, 64'(d_sv[0]), 64'hF);
        next_cycle();
        reset = 1;
        next_cycle();
        reset = 0; rd_en = 0; rd_idx = 0;
        @(negedge clk);
        check("rst_valid", 0, 64'(d_sv[0]), 64'h0);
        check("rst_stall", 0, 64'(d_st[0]), 64'h0);
        check("rst_wb_en", 0, 64'(d_wbe[0]), 64'h0);
        check("rst_instret", 0, d_cnt[0], 64'h0);

        // ALU producer x5 in EX, consumer in ID
        next_cycle();
        rd_en = 1; rd_idx = 5'd5;
        next_cycle();
        rd_en = 0; rd_idx = 0; if_valid = 0;
        rs1_en = 1; rs1_idx = 5'd5; rs2_en = 1; rs2_idx = 5'd0;
        @(negedge clk);
        check("alu_rs1_sel", 0, 64'(d_s1[0]), 64'd2);
        check("alu_rs2_sel", 0, 64'(d_s2[0]), 64'd0);
        check("alu_hazard", 0, 64'(d_hz[0]), 64'd0);
        check("nofwd_hazard", 1, 64'(d_hz[1]), 64'd1);
        check("nofwd_rs1_sel", 1, 64'(d_s1[1]), 64'd0);
        check("deep_rs1_sel", 2, 64'(d_s1[2]), 64'd2);
        next_cycle();
        idle_inputs();
        repeat (8) next_cycle();

        // load producer x7 in EX, consumer in ID
        if_valid = 1;
        next_cycle();
        rd_en = 1; rd_idx = 5'd7; is_load = 1;
        next_cycle();
        rd_en = 0; rd_idx = 0; is_load = 0; if_valid = 0; rs1_en = 1; rs1_idx = 5'd7;
        @(negedge clk);
        check("ld_hazard1", 0, 64'(d_hz[0]), 64'd1);
        check("ld_stall1", 0, 64'(d_st[0]), 64'b00011);
        next_cycle();
        @(negedge clk);
        check("ld_valid2", 0, 64'(d_sv[0]), 64'b0101);
        check("ld_hazard2", 0, 64'(d_hz[0]), 64'd1);
        check("ld_stall2", 0, 64'(d_st[0]), 64'b00011);
        next_cycle();
        @(negedge clk);
        check("ld_valid3", 0, 64'(d_sv[0]), 64'b1001);
        check("ld_hazard3", 0, 64'(d_hz[0]), 64'd0);
        check("ld_rs1_sel", 0, 64'(d_s1[0]), 64'd4);
        next_cycle();
        idle_inputs();
        repeat (8) next_cycle();

        // redirect with a full pipe
        if_valid = 1;
        repeat (4) next_cycle();
        redir = 1;
        @(negedge clk);
        check("redir_stall", 0, 64'(d_st[0]), 64'd0);
        next_cycle();
        redir = 0;
        @(negedge clk);
        check("redir_valid", 0, 64'(d_sv[0]), 64'b1100);

        // three busy cycles, exception in the second
        rd_en = 1; rd_idx = 5'd9;
        repeat (4) next_cycle();
        busy = 1;
        @(negedge clk);
        check("busy_stall1", 0, 64'(d_st[0]), 64'b01111);
        check("busy_valid1", 0, 64'(d_sv[0]), 64'b1111);
        next_cycle();
        excp = 1;
        @(negedge clk);
        check("busy_stall2", 0, 64'(d_st[0]), 64'b01111);
        check("busy_valid2", 0, 64'(d_sv[0]), 64'b0111);
        next_cycle();
        excp = 0;
        @(negedge clk);
        check("busy_stall3", 0, 64'(d_st[0]), 64'b01111);
        check("busy_valid3", 0, 64'(d_sv[0]), 64'b0100);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("unbusy_stall", 0, 64'(d_st[0]), 64'd0);
        check("unbusy_valid", 0, 64'(d_sv[0]), 64'b0100);
        next_cycle();
        @(negedge clk);
        check("retire_valid", 0, 64'(d_sv[0]), 64'b1000);
        check("retire_wb_en", 0, 64'(d_wbe[0]), 64'd1);
        check("retire_wb_idx", 0, 64'(d_wbi[0]), 64'd9);

        // 4-bit counter wrap
        next_cycle();
        reset = 1;
        next_cycle();
        reset = 0; if_valid = 1;
        repeat (19) next_cycle();
        @(negedge clk);
        check("cnt4_15", 1, d_cnt[1], 64'd15);
        next_cycle();
        @(negedge clk);
        check("cnt4_wrap", 1, d_cnt[1], 64'd0);
        check("cnt64_16", 0, d_cnt[0], 64'd16);
        next_cycle();
        @(negedge clk);
        check("cnt4_end", 1, d_cnt[1], 64'd1);
        check("cnt64_17", 0, d_cnt[0], 64'd17);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset    = ($urandom_range(0, 199) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            rs1_en   = 1'($urandom_range(0, 1));
            rs1_idx  = 5'($urandom_range(0, 3));
            rs2_en   = 1'($urandom_range(0, 1));
            rs2_idx  = 5'($urandom_range(0, 3));
            rd_en    = ($urandom_range(0, 3) != 0);
            rd_idx   = 5'($urandom_range(0, 3));
            is_load  = ($urandom_range(0, 3) == 0);
            redir    = ($urandom_range(0, 9) == 0);
            excp     = ($urandom_range(0, 19) == 0);
            busy     = ($urandom_range(0, 5) == 0);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
